// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage that streams sequential fetches into a DEPTH-entry
// prefetch queue; decode drains {pc, instr} through a valid/ready handshake.
module if_prefetch_queue #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         imem_req,
  output logic [XLEN-1:0]              imem_addr,
  input  logic [ILEN-1:0]              imem_rdata,
  input  logic                         id_ready,
  output logic                         if_valid,
  output logic [ILEN-1:0]              if_instr,
  output logic [XLEN-1:0]              if_pc,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  entry_t          queue [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc, issuedPc;
  logic            inflight;
  logic [CW:0]     reserved;
  logic            push, pop;

  // A slot is reserved at issue time, so the response always finds room.
  assign reserved  = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req  = !rst && !redirect_valid && (reserved < (CW+1)'(DEPTH));
  assign imem_addr = pc;
  assign push      = inflight && !redirect_valid;
  assign pop       = if_valid && id_ready && !redirect_valid;
  assign q_count   = count;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    if (count != '0) begin
      if_valid = 1'b1;
      if_instr = queue[rdPtr].instr;
      if_pc    = queue[rdPtr].pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      issuedPc <= '0;
      inflight <= 1'b0;
      count    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc       <= pc + XLEN'(PC_STEP);
        issuedPc <= pc;
      end
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage is not reset; count and pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push) queue[wrPtr] <= '{pc: issuedPc, instr: imem_rdata};
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: hand-computed pipeline timing plus an
// in-order PC scoreboard on every decode pop; memory returns mem[addr/4] = addr/4.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, id_ready;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic [2:0]  q_count;

  logic        rst2;
  logic        req2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc2;
  logic [2:0]  count2;

  int          nVectors = 0;
  int          nMiscompares = 0;
  logic [31:0] expPc = '0;

  always #5 clk = ~clk;

  if_prefetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .q_count(q_count)
  );

  if_prefetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dutWrap (
    .clk(clk), .rst(rst2), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .id_ready(1'b1), .if_valid(valid2), .if_instr(instr2), .if_pc(pc2),
    .q_count(count2)
  );

  // Instruction memory: one-cycle read latency, mem[i] = i.
  always @(posedge clk) begin
    imem_rdata <= imem_addr >> 2;
    rdata2     <= addr2 >> 2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs mid-cycle, let combinational outputs settle,
  // then check any pop against the in-order scoreboard.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy, input logic r);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    rst            = r;
    #1;
    if (r) begin
      expPc = 32'h0;
    end else if (rv) begin
      expPc = rpc;
    end else if (rdy && if_valid) begin
      check("pop_pc", if_pc, expPc);
      check("pop_instr", if_instr, expPc >> 2);
      expPc = expPc + 32'd4;
    end
  endtask

  int stallCount [10] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4};
  int stallReq   [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] wrapPc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  initial begin
    rst = 1'b1; rst2 = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Reset state
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);

    // 1: streaming at one instruction per cycle
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("stream_req", 32'(imem_req), 32'd1);
      check("stream_addr", imem_addr, 32'(4 * c));
      check("stream_valid", 32'(if_valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) check("stream_pc", if_pc, 32'(4 * (c - 2)));
    end

    // 2: decode stall fills the queue, then drains in order
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("stall_count", 32'(q_count), 32'(stallCount[k]));
      check("stall_req", 32'(imem_req), 32'(stallReq[k]));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("resume_count0", 32'(q_count), 32'd4);
    check("resume_req0", 32'(imem_req), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("resume_count1", 32'(q_count), 32'd3);
    check("resume_req1", 32'(imem_req), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("resume_count2", 32'(q_count), 32'd2);
    for (int k = 0; k < 6; k++) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // 3: redirect with three queued entries and one fetch in flight
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    check("redir_noissue", 32'(imem_req), 32'd0);
    for (int k = 0; k < 4; k++) drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    check("redir_q3_count", 32'(q_count), 32'd3);
    check("redir_q3_head", if_pc, 32'h10);
    check("redir_q3_req", 32'(imem_req), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("redir_n1_count", 32'(q_count), 32'd0);
    check("redir_n1_valid", 32'(if_valid), 32'd0);
    check("redir_n1_addr", imem_addr, 32'h40);
    check("redir_n1_req", 32'(imem_req), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("redir_n2_count", 32'(q_count), 32'd0);
    check("redir_n2_valid", 32'(if_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("redir_n3_valid", 32'(if_valid), 32'd1);
    check("redir_n3_pc", if_pc, 32'h40);
    check("redir_n3_instr", if_instr, 32'h10);
    for (int k = 0; k < 3; k++) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // 4: redirect coinciding with a pop and a response arrival
    drive(1'b1, 32'h80, 1'b1, 1'b0);
    check("coin_valid", 32'(if_valid), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("coin_n1_count", 32'(q_count), 32'd0);
    check("coin_n1_valid", 32'(if_valid), 32'd0);
    check("coin_n1_addr", imem_addr, 32'h80);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("coin_n2_valid", 32'(if_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("coin_n3_pc", if_pc, 32'h80);
    for (int k = 0; k < 4; k++) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // 6: reset mid-stream with a full queue
    for (int k = 0; k < 5; k++) drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("full_count", 32'(q_count), 32'd4);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("midrst_req", 32'(imem_req), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("postrst_count", 32'(q_count), 32'd0);
    check("postrst_valid", 32'(if_valid), 32'd0);
    check("postrst_addr", imem_addr, 32'h0);
    check("postrst_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 4; k++) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // 5: PC wrap on the RESET_PC = FFFF_FFF8 instance
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst2 = 1'b0;
    #1;
    check("wrap_addr0", addr2, 32'hFFFF_FFF8);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_addr1", addr2, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_addr2", addr2, 32'h0000_0000);
    for (int k = 0; k < 3; k++) begin
      check("wrap_valid", 32'(valid2), 32'd1);
      check("wrap_pc", pc2, wrapPc[k]);
      check("wrap_instr", instr2, wrapPc[k] >> 2);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
